// File: rtl/prpg_checker.sv
// prpg_checker: receive-side checker for the 3-bit PRPG stream (period 7).
// Hunts for a legal sample, verifies LOCK_COUNT consecutive predictions,
// then flywheels the prediction while counting mismatches and folding the
// locked stream into a 3-bit MISR signature.
module prpg_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       din_valid,
    input  logic [2:0] din,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [2:0] expected,
    output logic [2:0] signature
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_TARGET = 4'(LOSS_COUNT);

    state_t     state;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    // One step of the x^3+x^2+1 recurrence; also the MISR feedback.
    function automatic logic [2:0] step(input logic [2:0] v);
        step = {v[1], v[0], v[0] ^ v[2]};
    endfunction

    // Sequencer: hunt / verify / locked tracking, error counting and signature.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'd0;
            expected  <= 3'b001;
            signature <= 3'b000;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the
            // pre-edge values and later assignments here simply override earlier ones.
            err <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (din != 3'b000) begin
                            expected  <= step(din);
                            match_cnt <= 4'd0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (din == expected) begin
                            expected <= step(din);
                            if (match_cnt + 4'd1 == LOCK_TARGET) begin
                                match_cnt <= 4'd0;
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                signature <= 3'b000;
                                miss_cnt  <= 4'd0;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end else if (din != 3'b000) begin
                            expected  <= step(din);
                            match_cnt <= 4'd0;
                        end else begin
                            match_cnt <= 4'd0;
                            state     <= HUNT;
                        end
                    end
                    LOCKED: begin
                        expected  <= step(expected);
                        signature <= step(signature) ^ din;
                        if (din == expected) begin
                            miss_cnt <= 4'd0;
                        end else begin
                            err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                            if (miss_cnt + 4'd1 == LOSS_TARGET) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                expected <= 3'b001;
                                miss_cnt <= 4'd0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Clear is applied last so it wins over any same-edge accumulation.
            if (clear) begin
                err_count <= 8'd0;
                signature <= 3'b000;
            end
        end
    end

endmodule

// File: doc/prpg_checker.md
# prpg_checker

Receive-side checker for the 3-bit pattern stream produced by the team's PRPG (x³+x²+1 style recurrence, period 7). It sits at the far end of a BIST path: it samples the incoming 3-bit pattern, synchronises to the sequence, and flags mismatches. It also accumulates a 3-bit MISR signature of the locked stream, so the test controller can compare one value instead of watching every cycle.

## Interface
- LOCK_COUNT, 3: consecutive correct predictions after seeding required to declare lock (1..15).
- LOSS_COUNT, 2: consecutive mismatches while locked that drop lock (1..15).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of err_count and signature; lower priority than rst.
- din_valid  in  1  din is a valid sample this cycle.
- din  in  3  received pattern, bit0=Q1, bit1=Q2, bit2=Q3.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse per mismatched sample in LOCKED.
- err_count  out  8  saturating mismatch count (stops at 255).
- expected  out  3  predicted value of the next valid sample.
- signature  out  3  MISR accumulator.

## Operation
- step(v): n[0]=v[0]^v[2], n[1]=v[0], n[2]=v[1]. Legal sequence: 001→011→111→110→101→010→100→001. 000 is illegal (lock-up state).
- Reset values: state HUNT, locked=0, err=0, err_count=0, expected=001, signature=000, match_cnt=0, miss_cnt=0.
- din_valid=0: every register holds, and err=0.
- HUNT, valid d:
  - d=000: stay in HUNT.
  - Otherwise: expected←step(d), match_cnt←0, go to VERIFY.
- VERIFY, valid d:
  - d==expected: expected←step(d), match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED, set signature←000 and miss_cnt←0.
  - Mismatch with d≠000: reseed expected←step(d), match_cnt←0, stay in VERIFY.
  - d=000: go to HUNT.
  - err never pulses in VERIFY.
- LOCKED, valid d:
  - Always: expected←step(expected) (flywheel; prediction advances even on error) and signature←step(signature)^d.
  - Match: miss_cnt←0.
  - Mismatch: err=1, err_count increments (saturating), miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked←0, expected←001, miss_cnt←0. signature and err_count hold.
- clear=1 (no rst): err_count←0 and signature←000 at that edge; the state machine is unaffected.
- clear together with a LOCKED valid sample: the cleared value wins, so the sample is not accumulated and no count is added. err still pulses on a mismatch.
- rst mid-operation: all reset values apply at that edge regardless of din_valid or clear.

## Timing
- All outputs are registered. A sample taken at edge k is reflected in the outputs immediately after edge k.
- Lock latency: 1 seed sample + LOCK_COUNT matches. With defaults, locked rises after the 4th consecutive valid legal sample.
- err: high for exactly the cycle following the edge that sampled the bad value. Back-to-back mismatches give back-to-back pulses.
- Loss latency: LOSS_COUNT consecutive mismatched valid samples. locked falls after the edge of the last one, and err is high in that same cycle.
- Invalid cycles between samples do not break "consecutive"; only valid samples are counted.
- err_count at 255 stays at 255, and err still pulses.

## Test plan
- Lock acquisition:
  - Stimulus: rst, then valid 001, 011, 111, 110 on consecutive cycles.
  - Required: locked=1 after the 4th edge, expected=101, err_count=0, signature=000.
- Full period and signature:
  - Stimulus: after lock, feed 101, 010, 100, 001, 011, 111, 110.
  - Required: locked stays 1, err never pulses, expected=101 (wrap-around), signature=110.
- Single error, flywheel recovery:
  - Stimulus: locked and expecting 111; send 000, then 110.
  - Required: err pulses once, err_count=1, locked stays 1, 110 is accepted without err, miss_cnt is back to 0.
- Loss of lock:
  - Stimulus: locked and expecting 101; send 000, 000.
  - Required: err pulses twice, err_count=2, locked=0 after the 2nd edge; a following 000 keeps the block in HUNT.
- Gaps and VERIFY reseed:
  - Stimulus: 011, idle 3 cycles, 111, then 010 (mismatch), 100, 001, 011.
  - Required: no err pulses; locked=1 after 011 (reseeded at 010).
- Clear and reset:
  - Stimulus: locked with err_count=2, pulse clear.
  - Required: err_count=0 and signature=000 while locked stays 1. A later rst while locked returns every output to its reset value at that edge.
